// File: rtl/fp16_divider.sv
// Sequential IEEE-754 half-precision divider using restoring mantissa division (quotient = dividend / divisor).
// Latency: fixed 15 cycles from the accept edge to out_valid, special operands included; one operation in flight.
// Backpressure: in_ready only in IDLE; quotient/flags hold in DONE until out_ready, then return to IDLE.
module fp16_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int EXPONENT   = 5,
    parameter int MANTISSA   = 10,
    parameter int BIAS       = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [2:0]            flags
);

    localparam int SIG_W  = MANTISSA + 1;        // significand with hidden bit
    localparam int REM_W  = MANTISSA + 2;        // remainder, one guard bit above the divisor
    localparam int QUO_W  = MANTISSA + 3;        // integer bit + mantissa + round bit
    localparam int EXP_W  = EXPONENT + 2;        // signed exponent path
    localparam int LAST_IT = QUO_W - 1;
    localparam logic [EXPONENT-1:0] EXP_MAX = {EXPONENT{1'b1}};
    localparam logic [DATA_WIDTH-1:0] QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    sign_q, sign_d;
    logic [EXPONENT-1:0]     ea_q, ea_d, eb_q, eb_d;
    logic                    za_q, za_d, zb_q, zb_d, ia_q, ia_d, ib_q, ib_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic [SIG_W-1:0]        mb_q, mb_d;
    logic [QUO_W-1:0]        q_q, q_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic [2:0]              flags_q, flags_d;
    logic                    out_valid_q, out_valid_d;

    // Operand field decode, used only on the accept cycle
    logic [EXPONENT-1:0] ea_in, eb_in;
    logic [SIG_W-1:0]    ma_in, mb_in;

    // Normalise/round/special-case results, consumed in NORM
    logic [EXP_W-1:0]    e_raw, e_fin;
    logic [MANTISSA-1:0] mant_n, mant_fin;
    logic [MANTISSA:0]   mant_inc;
    logic                rnd_bit, sticky, inc, rem_nz;
    logic [DATA_WIDTH-1:0] norm_res;
    logic [2:0]          norm_flags;

    // Restoring step signals
    logic                ge;
    logic [REM_W-1:0]    rem_sub;

    assign ea_in = dividend[DATA_WIDTH-2 -: EXPONENT];
    assign eb_in = divisor[DATA_WIDTH-2 -: EXPONENT];
    assign ma_in = {1'b1, dividend[MANTISSA-1:0]};
    assign mb_in = {1'b1, divisor[MANTISSA-1:0]};

    assign ge      = rem_q >= {1'b0, mb_q};
    assign rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = res_q;
    assign flags     = flags_q;

    // State and datapath registers; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            za_q        <= 1'b0;
            zb_q        <= 1'b0;
            ia_q        <= 1'b0;
            ib_q        <= 1'b0;
            rem_q       <= '0;
            mb_q        <= '0;
            q_q         <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            za_q        <= za_d;
            zb_q        <= zb_d;
            ia_q        <= ia_d;
            ib_q        <= ib_d;
            rem_q       <= rem_d;
            mb_q        <= mb_d;
            q_q         <= q_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: accept in IDLE, 13 restoring steps, one normalise cycle, then hold the result
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        za_d        = za_q;
        zb_d        = zb_q;
        ia_d        = ia_q;
        ib_d        = ib_q;
        rem_d       = rem_q;
        mb_d        = mb_q;
        q_d         = q_q;
        res_d       = res_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                    ea_d    = ea_in;
                    eb_d    = eb_in;
                    // Subnormals flush to zero, NaN inputs behave as Inf
                    za_d    = (ea_in == '0);
                    zb_d    = (eb_in == '0);
                    ia_d    = (ea_in == EXP_MAX);
                    ib_d    = (eb_in == EXP_MAX);
                    rem_d   = {1'b0, ma_in};
                    mb_d    = mb_in;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // Remainder stays below the divisor after the subtract, so the shift never overflows
                q_d   = {q_q[QUO_W-2:0], ge};
                rem_d = {rem_sub[REM_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(LAST_IT)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                res_d   = norm_res;
                flags_d = norm_flags;
                state_d = DONE;
            end
            DONE: begin
                // out_valid launches from a flop one cycle into DONE so the writeback side sees registered timing
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Normalise, round-to-nearest-even, range clamp and special-case priority
    always_comb begin
        rem_nz = (rem_q != '0);
        if (q_q[QUO_W-1]) begin
            mant_n  = q_q[QUO_W-2:2];
            rnd_bit = q_q[1];
            sticky  = q_q[0] | rem_nz;
            e_raw   = {2'b00, ea_q} - {2'b00, eb_q} + EXP_W'(BIAS);
        end else begin
            mant_n  = q_q[QUO_W-3:1];
            rnd_bit = q_q[0];
            sticky  = rem_nz;
            e_raw   = {2'b00, ea_q} - {2'b00, eb_q} + EXP_W'(BIAS - 1);
        end

        inc      = rnd_bit & (sticky | mant_n[0]);
        mant_inc = {1'b0, mant_n} + {{MANTISSA{1'b0}}, inc};
        if (mant_inc[MANTISSA]) begin
            mant_fin = '0;
            e_fin    = e_raw + EXP_W'(1);
        end else begin
            mant_fin = mant_inc[MANTISSA-1:0];
            e_fin    = e_raw;
        end

        norm_flags = 3'b000;
        if ((za_q && zb_q) || (ia_q && ib_q)) begin
            norm_res   = QNAN;
            norm_flags = 3'b100;
        end else if (zb_q) begin
            norm_res   = {sign_q, EXP_MAX, {MANTISSA{1'b0}}};
            norm_flags = 3'b010;
        end else if (ia_q) begin
            norm_res   = {sign_q, EXP_MAX, {MANTISSA{1'b0}}};
        end else if (za_q || ib_q) begin
            norm_res   = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        end else if ($signed(e_fin) >= $signed(EXP_W'(EXP_MAX))) begin
            norm_res   = {sign_q, EXP_MAX, {MANTISSA{1'b0}}};
            norm_flags = 3'b001;
        end else if ($signed(e_fin) <= $signed(EXP_W'(0))) begin
            norm_res   = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            norm_res   = {sign_q, e_fin[EXPONENT-1:0], mant_fin};
        end
    end

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider: directed vectors, backpressure, mid-operation reset, random operands.
// Expected results come from constants or an integer long-division model and pass through a scoreboard queue.
// Every wait on the DUT is bounded; expired bounds count as failures.
module tb_fp16_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [2:0]  flags;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [18:0] sb_q[$];

    always #5 clk = ~clk;

    fp16_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    // Reference: quotient bits = floor(ma * 2^12 / mb), sticky from the true remainder
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, num, qv, rem, e, mant, rb, st;
        logic s;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 0 && eb == 0) || (ea == 31 && eb == 31)) return {3'b100, 16'h7E00};
        if (eb == 0) return {3'b010, s, 5'h1F, 10'h000};
        if (ea == 31) return {3'b000, s, 5'h1F, 10'h000};
        if (ea == 0 || eb == 31) return {3'b000, s, 15'h0000};
        ma  = 1024 + int'(a[9:0]);
        mb  = 1024 + int'(b[9:0]);
        num = ma * 4096;
        qv  = num / mb;
        rem = num % mb;
        if (qv >= 4096) begin
            mant = (qv >> 2) & 1023;
            rb   = (qv >> 1) & 1;
            st   = ((qv & 1) != 0 || rem != 0) ? 1 : 0;
            e    = ea - eb + 15;
        end else begin
            mant = (qv >> 1) & 1023;
            rb   = qv & 1;
            st   = (rem != 0) ? 1 : 0;
            e    = ea - eb + 14;
        end
        if (rb == 1 && (st == 1 || (mant & 1) == 1)) mant++;
        if (mant == 1024) begin
            mant = 0;
            e++;
        end
        if (e >= 31) return {3'b001, s, 5'h1F, 10'h000};
        if (e <= 0) return {3'b000, s, 15'h0000};
        return {3'b000, s, e[4:0], mant[9:0]};
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [18:0] expv, input int hold);
        logic [15:0] q0;
        logic [2:0]  f0;
        logic [18:0] e;
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'd15);
        if (!out_valid) begin
            void'(sb_q.pop_front());
            return;
        end
        q0 = quotient;
        f0 = flags;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 1);
            dividend = 16'h4400;
            divisor  = 16'h3C00;
            @(posedge clk);
            #1;
            chk("hold_quotient", 32'(quotient), 32'(q0));
            chk("hold_flags", 32'(flags), 32'(f0));
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("return_in_ready", 32'(in_ready), 32'd1);
        chk("return_out_valid", 32'(out_valid), 32'd0);
        e = sb_q.pop_front();
        chk($sformatf("result %h/%h", a, b), {13'b0, f0, q0}, {13'b0, e});
    endtask

    function automatic logic [15:0] rand_fp();
        logic [4:0] ex;
        if ($urandom_range(0, 7) == 0) ex = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
        else ex = 5'($urandom_range(1, 30));
        return {1'($urandom_range(0, 1)), ex, 10'($urandom_range(0, 1023))};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'h0000;
        divisor   = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;

        run_op(16'h4000, 16'h3C00, {3'b000, 16'h4000}, 0);
        run_op(16'h3C00, 16'h4200, {3'b000, 16'h3555}, 0);
        run_op(16'hC500, 16'h4000, {3'b000, 16'hC100}, 0);
        run_op(16'h3C00, 16'h0000, {3'b010, 16'h7C00}, 0);
        run_op(16'h0000, 16'h0000, {3'b100, 16'h7E00}, 0);
        run_op(16'h8000, 16'h4000, {3'b000, 16'h8000}, 0);
        run_op(16'h7BFF, 16'h1400, {3'b001, 16'h7C00}, 0);
        run_op(16'h0400, 16'h4000, {3'b000, 16'h0000}, 0);
        run_op(16'h7C00, 16'h7C00, {3'b100, 16'h7E00}, 0);
        run_op(16'hFC00, 16'h4000, {3'b000, 16'hFC00}, 0);
        run_op(16'h4000, 16'hFC00, {3'b000, 16'h8000}, 0);
        run_op(16'h3C00, 16'h4200, {3'b000, 16'h3555}, 5);

        // Reset while the divide loop is at step 6
        @(negedge clk);
        dividend = 16'h4400;
        divisor  = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_quotient", 32'(quotient), 32'd0);
        rst = 1'b0;
        run_op(16'h4400, 16'h3C00, {3'b000, 16'h4400}, 0);

        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            run_op(ra, rb, model(ra, rb), (i % 8 == 3) ? 2 : 0);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fp16_divider.md
Name: fp16_divider

Overview:
Sequential IEEE-754 half-precision divider. It computes quotient = dividend / divisor using iterative restoring mantissa division and is the inverse companion of the combinational FP16 multiplier in the systolic array. It is used for post-array normalisation and scaling, and sits between the array output collector and the result writeback. Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
DATA_WIDTH, 16, word width. Only 16 is supported.
EXPONENT, 5, exponent field width.
MANTISSA, 10, stored mantissa width.
BIAS, 15, exponent bias.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  divider idle; can accept operands
dividend  input  16  FP16 numerator
divisor  input  16  FP16 denominator
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
quotient  output  16  FP16 result
flags  output  3  {invalid, div_by_zero, overflow}; valid while out_valid is high

Behaviour:
- Reset values: in_ready=1, out_valid=0, quotient=0, flags=0. The FSM goes to IDLE. Reset mid-operation discards the operation.
- FSM states: IDLE, DIVIDE, NORM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the operands, set the iteration counter to 0, and go to DIVIDE.
- DIVIDE: runs for exactly 13 cycles (counter 0..12), then goes to NORM.
- NORM: 1 cycle. Performs normalise, round, and special-case selection, then goes to DONE.
- DONE: out_valid=1. quotient and flags are held stable until out_ready=1, then the FSM returns to IDLE.
- in_ready is low in every state except IDLE. Operands are accepted in IDLE only, so there is no same-cycle accept/return.
- Fixed latency: out_valid rises 15 clock edges after the accept edge, for all inputs including special cases.
- Decode rules:
  - Exponent 0 means zero; subnormals are flushed to zero.
  - Exponent 31 means Inf; NaN inputs are treated as Inf.
  - Otherwise the significand is {1, mant}.
- Mantissa division:
  - Remainder R (12 bits) starts at ma.
  - Each cycle: if R >= mb, set q bit to 1 and R = R - mb, else q bit is 0; then R = R << 1.
  - This produces q[12:0] MSB-first, with q[12] as the integer bit.
- Normalisation:
  - If q[12]=1: mant = q[11:2], round bit = q[1], sticky = q[0] | (R != 0), e = ea - eb + 15.
  - Else: mant = q[10:1], round bit = q[0], sticky = (R != 0), e = ea - eb + 14.
  - The exponent path is a 7-bit signed computation.
- Rounding: round-to-nearest-even. Increment when round & (sticky | mant[0]). If mant overflows on increment, mant = 0 and e = e + 1.
- Sign: sign = sa ^ sb for all results, including zero and Inf. The one exception is NaN, which is always 0x7E00.
- Range handling:
  - If e >= 31: result is signed Inf (exp=31, mant=0) and overflow=1.
  - If e <= 0: result is signed zero, with no flag.
- Special cases take priority over the arithmetic result. The result is still delivered after 15 cycles. Cases in priority order:
  1. 0/0 or Inf/Inf: result 0x7E00, invalid=1.
  2. x/0 with x nonzero: signed Inf, div_by_zero=1.
  3. Inf/x: signed Inf, no flag.
  4. 0/x or x/Inf: signed zero, no flag.
- in_valid asserted outside IDLE is ignored. Operand changes after the accept edge have no effect.

Test Plan:
- 0x4000 / 0x3C00 (2.0/1.0) -> quotient 0x4000, flags 0, out_valid exactly 15 edges after accept.
- 0x3C00 / 0x4200 (1/3) -> 0x3555 (round bit 0, no increment); 0xC500 / 0x4000 (-5/2) -> 0xC100.
- 0x3C00 / 0x0000 -> 0x7C00 with flags=3'b010; 0x0000 / 0x0000 -> 0x7E00 with flags=3'b100; 0x8000 / 0x4000 -> 0x8000 with flags 0.
- 0x7BFF / 0x1400 -> 0x7C00 with flags=3'b001; 0x0400 / 0x4000 (2^-15) -> 0x0000 with flags 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> quotient and flags stable, in_ready=0, in_valid pulses ignored; after out_ready=1, in_ready=1 on the next cycle.
- Assert rst during DIVIDE (counter=6) -> next cycle out_valid=0, in_ready=1, quotient=0; a new operation then completes normally with 15-cycle latency.
